// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

    localparam int FETCH_DEPTH_DEF = 4;
    localparam int FETCH_AW        = 32;
    localparam int FETCH_IW        = 32;

    // Instr value presented after reset.
    localparam logic [FETCH_IW-1:0] NOP_INSTR = 32'h0;

    // One queued fetch response: PC tag plus returned instruction word.
    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [FETCH_IW-1:0] instr;
    } fetch_entry_t;

    // Occupancy counters need one extra bit so DEPTH itself is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch response queue: DEPTH entries, registered head, synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEF,
    parameter int CW    = occ_width(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    fetch_entry_t  r_head;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_rd_nxt;
    logic [CW-1:0] w_cnt_nxt;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign head  = r_head;

    // Qualify handshakes so an empty pop or an overfull push can never corrupt state.
    always_comb begin
        w_pop     = pop & ~empty;
        w_push    = push & (~full | w_pop);
        w_rd_nxt  = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
        w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    // Pointer and occupancy update; flush dominates any push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            r_count <= w_cnt_nxt;
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= din;
    end

    // Registered head: preload the entry that will be at the front next cycle,
    // taking the incoming word directly when it lands in the head slot.
    // Holds its last value whenever the queue goes empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '{pc: '0, instr: NOP_INSTR};
        end else if (!flush && w_cnt_nxt != '0) begin
            r_head <= (w_push && w_rd_nxt == r_wr_ptr) ? din : r_mem[w_rd_nxt];
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: accepts fetch requests, drives a 1-cycle ROM,
// queues responses with their PC and hands them to decode via valid/ready.
// Optional perf counters (StallCnt/FlushCnt) under macro FETCH_PERF_CNT_EN.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEF,
    parameter int AW    = 32,
    parameter int IW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] ReqAddr,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic          Flush,
    output logic          ImemEn,
    output logic [AW-1:0] ImemAddr,
    input  logic [IW-1:0] ImemRdata,
    output logic          InstrValid,
    input  logic          InstrReady,
    output logic [IW-1:0] Instr,
    output logic [AW-1:0] InstrPC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   StallCnt,
    output logic [31:0]   FlushCnt
`endif
);

    localparam int CW = occ_width(DEPTH);

    logic          r_inflight;
    logic [AW-1:0] r_tag;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_din;
    fetch_entry_t  w_head;

    // Occupancy counts the in-flight read so its slot is reserved before issue.
    always_comb begin
        w_occ    = {1'b0, w_count} + (CW+1)'(r_inflight);
        ReqReady = start & ~Flush & (w_occ < (CW+1)'(DEPTH));
        w_accept = ReqValid & ReqReady;
        ImemEn   = w_accept;
        ImemAddr = w_accept ? ReqAddr : '0;
        w_pop    = InstrReady & ~w_empty;
        w_push   = r_inflight & ~Flush & (~w_full | w_pop);
        w_din    = '{pc: FETCH_AW'(r_tag), instr: FETCH_IW'(ImemRdata)};
    end

    // Track the single outstanding ROM read and its PC tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_tag      <= '0;
        end else if (Flush) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) r_tag <= ReqAddr;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (Flush),
        .din   (w_din),
        .head  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign InstrValid = ~w_empty;
    assign Instr      = IW'(w_head.instr);
    assign InstrPC    = AW'(w_head.pc);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating counts of blocked-request cycles and flush cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (ReqValid && start && !ReqReady && !Flush && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (Flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: queue-based reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_instr_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    logic        instr_ready = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] imem_rdata = '0;

    logic        ReqReady, ImemEn, InstrValid;
    logic [31:0] ImemAddr, Instr, InstrPC;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    instr_fetch_buffer #(.DEPTH(DEPTH), .AW(32), .IW(32)) dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .ReqAddr    (req_addr),
        .ReqValid   (req_valid),
        .ReqReady   (ReqReady),
        .Flush      (flush),
        .ImemEn     (ImemEn),
        .ImemAddr   (ImemAddr),
        .ImemRdata  (imem_rdata),
        .InstrValid (InstrValid),
        .InstrReady (instr_ready),
        .Instr      (Instr),
        .InstrPC    (InstrPC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hE3A01005 ^ ((a - 32'h10) << 4);
    endfunction

    // Synchronous ROM: data appears the cycle after the enable.
    always @(posedge clk) if (ImemEn) imem_rdata <= rom(ImemAddr);

    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    ent_t        q[$];
    ent_t        m_last;
    bit          m_infl;
    bit          m_acc;
    logic [31:0] m_tag;
    bit          wrap_on = 1'b0;
    int          wrap_idx = 0;
    int          n_pass = 0;
    int          n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        q.delete();
        m_infl = 1'b0;
        m_acc  = 1'b0;
        m_tag  = '0;
        m_last = '{pc: 32'h0, ins: 32'h0};
    endtask

    function automatic bit exp_ready();
        return start && !flush && (q.size() + int'(m_infl) < DEPTH);
    endfunction

    // Per-cycle comparison of every output against the model.
    task automatic check();
        bit   rr, acc;
        ent_t h;
        rr  = exp_ready();
        acc = req_valid && rr;
        h   = (q.size() != 0) ? q[0] : m_last;
        chk("ReqReady",   {31'b0, ReqReady},   {31'b0, rr});
        chk("ImemEn",     {31'b0, ImemEn},     {31'b0, acc});
        chk("ImemAddr",   ImemAddr,            acc ? req_addr : 32'h0);
        chk("InstrValid", {31'b0, InstrValid}, {31'b0, q.size() != 0});
        chk("Instr",      Instr,               h.ins);
        chk("InstrPC",    InstrPC,             h.pc);
        if (wrap_on && InstrValid && instr_ready) begin
            chk("wrap_order", InstrPC, 32'h200 + 32'(4 * wrap_idx));
            wrap_idx++;
        end
    endtask

    task automatic model_step();
        bit rr, pop;
        rr    = exp_ready();
        m_acc = req_valid && rr;
        pop   = (q.size() != 0) && instr_ready;
        if (q.size() != 0) m_last = q[0];
        if (flush) begin
            q.delete();
            m_infl = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_infl) q.push_back('{pc: m_tag, ins: rom(m_tag)});
            m_infl = m_acc;
            if (m_acc) m_tag = req_addr;
        end
        if (q.size() != 0) m_last = q[0];
    endtask

    // One clock: compare at negedge, advance model at posedge, return 1 after.
    task automatic cycle();
        @(negedge clk);
        check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int n;
        model_reset();

        // Reset state
        #1;
        chk("rst_InstrValid", {31'b0, InstrValid}, 32'h0);
        chk("rst_Instr",      Instr,               32'h0);
        chk("rst_InstrPC",    InstrPC,             32'h0);
        chk("rst_ImemEn",     {31'b0, ImemEn},     32'h0);
        chk("rst_ImemAddr",   ImemAddr,            32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_ReqReady_start0", {31'b0, ReqReady}, 32'h0);
        cycle();

        // Single fetch latency: accept at N, visible at N+2
        start = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
        cycle();
        req_valid = 1'b0;
        cycle();
        chk("lat_InstrValid", {31'b0, InstrValid}, 32'h1);
        chk("lat_Instr",      Instr,               32'hE3A01005);
        chk("lat_InstrPC",    InstrPC,             32'h10);
        cycle();

        // Async reset mid-cycle while an entry is queued
        #2;
        start = 1'b0; rst = 1'b1;
        #1;
        chk("arst_InstrValid", {31'b0, InstrValid}, 32'h0);
        chk("arst_Instr",      Instr,               32'h0);
        chk("arst_InstrPC",    InstrPC,             32'h0);
        chk("arst_ImemEn",     {31'b0, ImemEn},     32'h0);
        chk("arst_ImemAddr",   ImemAddr,            32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst_ReqReady", {31'b0, ReqReady}, 32'h0);
        cycle();

        // Fill to full with decode stalled
        start = 1'b1; instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_addr = 32'(4 * k);
            cycle();
        end
        req_addr = 32'h10;
        #1;
        chk("full_ReqReady_inflight", {31'b0, ReqReady}, 32'h0);
        cycle();
        cycle();
        chk("full_ReqReady", {31'b0, ReqReady}, 32'h0);
        req_valid = 1'b0; instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("fill_order_pc",  InstrPC, 32'(4 * k));
            chk("fill_order_ins", Instr,   rom(32'(4 * k)));
            cycle();
        end
        chk("fill_drained", {31'b0, InstrValid}, 32'h0);

        // Full queue then streaming push and pop together
        instr_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1; req_addr = 32'h80 + 32'(4 * k);
            cycle();
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            req_valid = 1'b1; req_addr = 32'h100 + 32'(4 * k);
            cycle();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) cycle();

        // Flush with a read in flight
        instr_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h20;
        cycle();
        flush = 1'b1; req_addr = 32'h100;
        #1;
        chk("flush_ReqReady", {31'b0, ReqReady}, 32'h0);
        chk("flush_ImemEn",   {31'b0, ImemEn},   32'h0);
        cycle();
        flush = 1'b0;
        #1;
        chk("post_flush_valid", {31'b0, InstrValid}, 32'h0);
        chk("post_flush_ready", {31'b0, ReqReady},   32'h1);
        cycle();
        req_valid = 1'b0;
        cycle();
        chk("flush_next_pc",  InstrPC, 32'h100);
        chk("flush_next_ins", Instr,   rom(32'h100));
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();

        // Stream across pointer wrap with random decode stalls
        wrap_on = 1'b1; n = 0;
        for (int c = 0; c < 100; c++) begin
            if (n >= 10 && q.size() == 0 && !m_infl) break;
            req_valid = (n < 10); req_addr = 32'h200 + 32'(4 * n);
            instr_ready = 1'($urandom_range(0, 1));
            cycle();
            if (m_acc) n++;
        end
        wrap_on = 1'b0;
        req_valid = 1'b0;
        chk("wrap_count", 32'(wrap_idx), 32'd10);

`ifdef FETCH_PERF_CNT_EN
        // Counters: 3 blocked request cycles and 2 flushes from a clean reset
        rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            req_valid = 1'b1; req_addr = 32'h40 + 32'(4 * k);
            cycle();
        end
        req_valid = 1'b0; flush = 1'b1;
        cycle();
        cycle();
        flush = 1'b0;
        #1;
        chk("StallCnt", StallCnt, 32'd3);
        chk("FlushCnt", FlushCnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
